ram_1p_arb: RTL and testbench

Two-host arbiter and sequencer in front of the single-port `ram_1p` storage on the DE10-Lite build. It shares one RAM between the Ibex instruction-fetch and data ports, using the Ibex req/gnt/rvalid protocol. It adds byte-enable writes, which the RAM lacks, by doing a read-modify-write (RMW). It keeps at most one access in flight at the RAM, so responses always return in order.

---
 rtl/ram_1p_arb.sv | 159 +++++++++++++++
 tb/tb_ram_1p_arb.sv | 220 ++++++++++++++++++++++
 2 files changed

// File: rtl/ram_1p_arb.sv
// Two-host arbiter in front of a single-port RAM using the Ibex req/gnt/rvalid
// handshake. Byte-enable writes are emulated with a read-modify-write, and only
// one RAM access is ever outstanding, so responses return in request order.
module ram_1p_arb #(
   parameter int Width = 32,
   parameter int Depth = 128,
   parameter int Aw    = $clog2(Depth)
) (
   input  logic               clk_i,
   input  logic               rst_ni,

   input  logic               h0_req_i,
   output logic               h0_gnt_o,
   input  logic               h0_we_i,
   input  logic [Width/8-1:0] h0_be_i,
   input  logic [Aw-1:0]      h0_addr_i,
   input  logic [Width-1:0]   h0_wdata_i,
   output logic               h0_rvalid_o,
   output logic [Width-1:0]   h0_rdata_o,

   input  logic               h1_req_i,
   output logic               h1_gnt_o,
   input  logic               h1_we_i,
   input  logic [Width/8-1:0] h1_be_i,
   input  logic [Aw-1:0]      h1_addr_i,
   input  logic [Width-1:0]   h1_wdata_i,
   output logic               h1_rvalid_o,
   output logic [Width-1:0]   h1_rdata_o,

   output logic               ram_req_o,
   output logic               ram_write_o,
   output logic [Aw-1:0]      ram_addr_o,
   output logic [Width-1:0]   ram_wdata_o,
   input  logic               ram_rvalid_i,
   input  logic [Width-1:0]   ram_rdata_i
);

   localparam int Bw = Width / 8;

   typedef enum logic {ACCEPT, MERGE} state_e;

   state_e             state_q, state_d;
   logic               last_gnt_q;      // 0: h0 granted last, 1: h1 granted last
   logic               resp_pend_q, resp_pend_d;
   logic               resp_owner_q, resp_owner_d;
   logic [Aw-1:0]      lat_addr_q;
   logic [Bw-1:0]      lat_be_q;
   logic [Width-1:0]   lat_wdata_q;
   logic               lat_owner_q;

   logic               sel_h1;
   logic               gnt_any;
   logic               latch_en;
   logic               sel_we;
   logic [Bw-1:0]      sel_be;
   logic [Aw-1:0]      sel_addr;
   logic [Width-1:0]   sel_wdata;

   // Byte-wise merge: enabled bytes come from the new data, the rest from the RAM.
   function automatic logic [Width-1:0] merge_bytes(input logic [Width-1:0] new_data,
                                                    input logic [Width-1:0] old_data,
                                                    input logic [Bw-1:0]    be);
      logic [Width-1:0] res;
      res = old_data;
      for (int b = 0; b < Bw; b++) begin
         if (be[b]) res[8*b +: 8] = new_data[8*b +: 8];
      end
      return res;
   endfunction

   // Round-robin pick and mux of the winning host's request fields.
   always_comb begin
      sel_h1    = h1_req_i && (!h0_req_i || !last_gnt_q);
      sel_we    = sel_h1 ? h1_we_i    : h0_we_i;
      sel_be    = sel_h1 ? h1_be_i    : h0_be_i;
      sel_addr  = sel_h1 ? h1_addr_i  : h0_addr_i;
      sel_wdata = sel_h1 ? h1_wdata_i : h0_wdata_i;
   end

   // Next-state, grants and RAM command; a partial write diverts into MERGE.
   always_comb begin
      state_d      = state_q;
      h0_gnt_o     = 1'b0;
      h1_gnt_o     = 1'b0;
      gnt_any      = 1'b0;
      latch_en     = 1'b0;
      ram_req_o    = 1'b0;
      ram_write_o  = 1'b0;
      ram_addr_o   = '0;
      ram_wdata_o  = '0;
      resp_pend_d  = 1'b0;
      resp_owner_d = resp_owner_q;

      unique case (state_q)
         ACCEPT: begin
            if (h0_req_i || h1_req_i) begin
               gnt_any    = 1'b1;
               h0_gnt_o   = !sel_h1;
               h1_gnt_o   = sel_h1;
               ram_req_o  = 1'b1;
               ram_addr_o = sel_addr;
               if (!sel_we || (&sel_be)) begin
                  ram_write_o  = sel_we;
                  ram_wdata_o  = sel_wdata;
                  resp_pend_d  = 1'b1;
                  resp_owner_d = sel_h1;
               end else begin
                  // Fetch the old word; the host sees no response for this read.
                  latch_en = 1'b1;
                  state_d  = MERGE;
               end
            end
         end
         MERGE: begin
            if (ram_rvalid_i) begin
               ram_req_o    = 1'b1;
               ram_write_o  = 1'b1;
               ram_addr_o   = lat_addr_q;
               ram_wdata_o  = merge_bytes(lat_wdata_q, ram_rdata_i, lat_be_q);
               resp_pend_d  = 1'b1;
               resp_owner_d = lat_owner_q;
               state_d      = ACCEPT;
            end
         end
         default: state_d = ACCEPT;
      endcase
   end

   // State, arbitration history, response tracking and the RMW capture.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q      <= ACCEPT;
         last_gnt_q   <= 1'b1;
         resp_pend_q  <= 1'b0;
         resp_owner_q <= 1'b0;
         lat_addr_q   <= '0;
         lat_be_q     <= '0;
         lat_wdata_q  <= '0;
         lat_owner_q  <= 1'b0;
      end else begin
         state_q      <= state_d;
         resp_pend_q  <= resp_pend_d;
         resp_owner_q <= resp_owner_d;
         if (gnt_any) last_gnt_q <= sel_h1;
         if (latch_en) begin
            lat_addr_q  <= sel_addr;
            lat_be_q    <= sel_be;
            lat_wdata_q <= sel_wdata;
            lat_owner_q <= sel_h1;
         end
      end
   end

   assign h0_rvalid_o = resp_pend_q && !resp_owner_q;
   assign h1_rvalid_o = resp_pend_q &&  resp_owner_q;
   assign h0_rdata_o  = ram_rdata_i;
   assign h1_rdata_o  = ram_rdata_i;

endmodule

// File: tb/tb_ram_1p_arb.sv
// Directed bench for ram_1p_arb with a 1-cycle-latency single-port RAM model.
module tb_ram_1p_arb;

   localparam int Width = 32;
   localparam int Depth = 128;
   localparam int Aw    = 7;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic             rst_ni;
   logic             h0_req, h0_gnt, h0_we, h0_rvalid;
   logic [3:0]       h0_be;
   logic [Aw-1:0]    h0_addr;
   logic [Width-1:0] h0_wdata, h0_rdata;
   logic             h1_req, h1_gnt, h1_we, h1_rvalid;
   logic [3:0]       h1_be;
   logic [Aw-1:0]    h1_addr;
   logic [Width-1:0] h1_wdata, h1_rdata;
   logic             ram_req, ram_write, ram_rvalid;
   logic [Aw-1:0]    ram_addr;
   logic [Width-1:0] ram_wdata, ram_rdata;

   ram_1p_arb #(.Width(Width), .Depth(Depth)) dut (
      .clk_i(clk), .rst_ni(rst_ni),
      .h0_req_i(h0_req), .h0_gnt_o(h0_gnt), .h0_we_i(h0_we), .h0_be_i(h0_be),
      .h0_addr_i(h0_addr), .h0_wdata_i(h0_wdata), .h0_rvalid_o(h0_rvalid), .h0_rdata_o(h0_rdata),
      .h1_req_i(h1_req), .h1_gnt_o(h1_gnt), .h1_we_i(h1_we), .h1_be_i(h1_be),
      .h1_addr_i(h1_addr), .h1_wdata_i(h1_wdata), .h1_rvalid_o(h1_rvalid), .h1_rdata_o(h1_rdata),
      .ram_req_o(ram_req), .ram_write_o(ram_write), .ram_addr_o(ram_addr),
      .ram_wdata_o(ram_wdata), .ram_rvalid_i(ram_rvalid), .ram_rdata_i(ram_rdata)
   );

   // Single-port RAM model: write lands at the edge, read data one cycle later.
   logic [Width-1:0] mem [Depth];
   int               wr_cnt = 0;
   always @(posedge clk) begin
      ram_rvalid <= ram_req;
      if (ram_req) begin
         if (ram_write) begin
            mem[ram_addr] <= ram_wdata;
            wr_cnt <= wr_cnt + 1;
         end else begin
            ram_rdata <= mem[ram_addr];
         end
      end
   end

   int errors = 0;
   int checks = 0;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic drv0(input logic req, input logic we, input logic [3:0] be,
                       input logic [Aw-1:0] addr, input logic [31:0] wdata);
      h0_req = req; h0_we = we; h0_be = be; h0_addr = addr; h0_wdata = wdata;
   endtask

   task automatic drv1(input logic req, input logic we, input logic [3:0] be,
                       input logic [Aw-1:0] addr, input logic [31:0] wdata);
      h1_req = req; h1_we = we; h1_be = be; h1_addr = addr; h1_wdata = wdata;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog expired: errors=%0d checks=%0d", errors, checks);
      $fatal(1, "watchdog");
   end

   logic [31:0] vals [4];
   int          w0;
   logic        exp_h0, prev_h0;

   initial begin
      vals[0] = 32'h0123_4567; vals[1] = 32'h89AB_CDEF;
      vals[2] = 32'hCAFE_F00D; vals[3] = 32'h5555_AAAA;
      rst_ni = 1'b0;
      drv0(0, 0, 4'h0, '0, '0);
      drv1(0, 0, 4'h0, '0, '0);

      // Reset state
      @(negedge clk); #1;
      chk("rst_h0_rvalid", 32'(h0_rvalid), 0);
      chk("rst_h1_rvalid", 32'(h1_rvalid), 0);
      chk("rst_ram_req", 32'(ram_req), 0);
      chk("rst_gnt", 32'({h0_gnt, h1_gnt}), 0);
      @(negedge clk); rst_ni = 1'b1;

      // Full write then read, h0
      @(negedge clk); drv0(1, 1, 4'hF, 5, 32'hDEADBEEF); #1;
      chk("fw_h0_gnt", 32'(h0_gnt), 1);
      chk("fw_h1_gnt", 32'(h1_gnt), 0);
      chk("fw_ram_cmd", 32'({ram_req, ram_write}), 32'b11);
      chk("fw_ram_addr", 32'(ram_addr), 5);
      chk("fw_ram_wdata", ram_wdata, 32'hDEADBEEF);
      @(negedge clk); drv0(1, 0, 4'hF, 5, '0); #1;
      chk("fw_rvalid", 32'(h0_rvalid), 1);
      chk("rd_h0_gnt", 32'(h0_gnt), 1);
      chk("rd_ram_cmd", 32'({ram_req, ram_write}), 32'b10);
      @(negedge clk); drv0(0, 0, 4'h0, '0, '0); #1;
      chk("rd_rvalid", 32'(h0_rvalid), 1);
      chk("rd_rdata", h0_rdata, 32'hDEADBEEF);
      chk("rd_h1_rvalid", 32'(h1_rvalid), 0);
      @(negedge clk); #1;
      chk("idle_rvalid", 32'(h0_rvalid), 0);

      // Byte write from h1 (RMW)
      @(negedge clk); drv1(1, 1, 4'b0010, 5, 32'h0000AA00); #1;
      chk("bw_h1_gnt", 32'(h1_gnt), 1);
      chk("bw_ram_cmd", 32'({ram_req, ram_write}), 32'b10);
      chk("bw_ram_addr", 32'(ram_addr), 5);
      @(negedge clk); drv1(0, 0, 4'h0, '0, '0); #1;
      chk("bw_merge_gnt", 32'({h0_gnt, h1_gnt}), 0);
      chk("bw_merge_cmd", 32'({ram_req, ram_write}), 32'b11);
      chk("bw_merge_addr", 32'(ram_addr), 5);
      chk("bw_merge_wdata", ram_wdata, 32'hDEADAAEF);
      chk("bw_no_early_rvalid", 32'(h1_rvalid), 0);
      @(negedge clk); #1;
      chk("bw_rvalid", 32'(h1_rvalid), 1);
      @(negedge clk); drv0(1, 0, 4'hF, 5, '0); #1;
      chk("bw_rd_gnt", 32'(h0_gnt), 1);
      chk("bw_rvalid_once", 32'(h1_rvalid), 0);
      @(negedge clk); drv0(0, 0, 4'h0, '0, '0); #1;
      chk("bw_rd_rvalid", 32'(h0_rvalid), 1);
      chk("bw_rd_rdata", h0_rdata, 32'hDEADAAEF);

      // RMW blocking: h1 partial write while h0 waits to read the same word
      @(negedge clk); drv0(1, 0, 4'hF, 5, '0); drv1(1, 1, 4'b1000, 5, 32'h1100_0000); #1;
      chk("blk_rr_h1_gnt", 32'(h1_gnt), 1);
      chk("blk_rr_h0_gnt", 32'(h0_gnt), 0);
      chk("blk_rd_cmd", 32'({ram_req, ram_write}), 32'b10);
      @(negedge clk); drv1(0, 0, 4'h0, '0, '0); #1;
      chk("blk_merge_gnt", 32'({h0_gnt, h1_gnt}), 0);
      chk("blk_merge_wdata", ram_wdata, 32'h11ADAAEF);
      @(negedge clk); #1;
      chk("blk_h0_gnt_t2", 32'(h0_gnt), 1);
      chk("blk_h1_rvalid_t2", 32'(h1_rvalid), 1);
      chk("blk_h0_ram_cmd", 32'({ram_req, ram_write}), 32'b10);
      @(negedge clk); drv0(0, 0, 4'h0, '0, '0); #1;
      chk("blk_h0_rvalid", 32'(h0_rvalid), 1);
      chk("blk_h0_rdata", h0_rdata, 32'h11ADAAEF);
      chk("blk_h1_rvalid_clr", 32'(h1_rvalid), 0);

      // Back-to-back full writes from h1 to addrs 0..3, then read back by h1
      w0 = wr_cnt;
      for (int i = 0; i < 4; i++) begin
         @(negedge clk); drv1(1, 1, 4'hF, Aw'(i), vals[i]); #1;
         chk($sformatf("b2b_gnt%0d", i), 32'(h1_gnt), 1);
         chk($sformatf("b2b_cmd%0d", i), 32'({ram_req, ram_write}), 32'b11);
         chk($sformatf("b2b_addr%0d", i), 32'(ram_addr), 32'(i));
         if (i > 0) chk($sformatf("b2b_rvalid%0d", i - 1), 32'(h1_rvalid), 1);
      end
      @(negedge clk); drv1(0, 0, 4'h0, '0, '0); #1;
      chk("b2b_rvalid3", 32'(h1_rvalid), 1);
      chk("b2b_write_count", 32'(wr_cnt - w0), 4);
      @(negedge clk); #1;
      chk("b2b_rvalid_done", 32'(h1_rvalid), 0);
      for (int j = 0; j < 4; j++) begin
         @(negedge clk); drv1(1, 0, 4'hF, Aw'(j), '0); #1;
         if (j > 0) begin
            chk($sformatf("rb_rvalid%0d", j - 1), 32'(h1_rvalid), 1);
            chk($sformatf("rb_rdata%0d", j - 1), h1_rdata, vals[j - 1]);
         end
      end
      @(negedge clk); drv1(0, 0, 4'h0, '0, '0); #1;
      chk("rb_rvalid3", 32'(h1_rvalid), 1);
      chk("rb_rdata3", h1_rdata, vals[3]);

      // Contention: both hosts hold read requests for 6 cycles
      prev_h0 = 1'b0;
      for (int k = 0; k < 6; k++) begin
         @(negedge clk); drv0(1, 0, 4'hF, 1, '0); drv1(1, 0, 4'hF, 2, '0); #1;
         exp_h0 = ((k % 2) == 0);
         chk($sformatf("rr_h0_gnt%0d", k), 32'(h0_gnt), 32'(exp_h0));
         chk($sformatf("rr_h1_gnt%0d", k), 32'(h1_gnt), 32'(!exp_h0));
         if (k > 0) begin
            chk($sformatf("rr_rvalid%0d", k - 1), 32'({h0_rvalid, h1_rvalid}),
                prev_h0 ? 32'b10 : 32'b01);
            chk($sformatf("rr_rdata%0d", k - 1), prev_h0 ? h0_rdata : h1_rdata,
                prev_h0 ? vals[1] : vals[2]);
         end
         prev_h0 = exp_h0;
      end
      @(negedge clk); drv0(0, 0, 4'h0, '0, '0); drv1(0, 0, 4'h0, '0, '0); #1;
      chk("rr_rvalid5", 32'({h0_rvalid, h1_rvalid}), 32'b01);
      chk("rr_rdata5", h1_rdata, vals[2]);

      // Reset in the MERGE cycle of an h0 partial write to addr 3
      @(negedge clk); drv0(1, 1, 4'b0001, 3, 32'h0000_00FF); #1;
      chk("rst_rmw_gnt", 32'(h0_gnt), 1);
      chk("rst_rmw_rd", 32'({ram_req, ram_write}), 32'b10);
      w0 = wr_cnt;
      @(negedge clk); drv0(0, 0, 4'h0, '0, '0); #1;
      chk("rst_rmw_in_merge", 32'({ram_req, ram_write}), 32'b11);
      rst_ni = 1'b0; #1;
      chk("rst_rmw_no_req", 32'(ram_req), 0);
      chk("rst_rmw_no_rvalid", 32'({h0_rvalid, h1_rvalid}), 0);
      @(negedge clk); #1;
      chk("rst_rmw_held_rvalid", 32'({h0_rvalid, h1_rvalid}), 0);
      rst_ni = 1'b1;
      @(negedge clk); drv0(1, 0, 4'hF, 3, '0); drv1(1, 0, 4'hF, 0, '0); #1;
      chk("rst_rel_h0_wins", 32'({h0_gnt, h1_gnt}), 32'b10);
      chk("rst_rel_accept_cmd", 32'({ram_req, ram_write}), 32'b10);
      chk("rst_rel_rvalid", 32'({h0_rvalid, h1_rvalid}), 0);
      @(negedge clk); drv0(0, 0, 4'h0, '0, '0); drv1(0, 0, 4'h0, '0, '0); #1;
      chk("rst_rel_rd_rvalid", 32'(h0_rvalid), 1);
      chk("rst_word_unchanged", h0_rdata, vals[3]);
      chk("rst_no_ram_write", 32'(wr_cnt - w0), 0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
